// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache (read) and dcache (read/write) word requests onto one RAM port.
// Define ARB_FAIRNESS_EN to bound dcache streaks while the icache is waiting.
module cache_mem_arbiter #(
    parameter int unsigned MAX_DBURST = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
);
    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    localparam int unsigned CW = ($clog2(MAX_DBURST + 1) > 3) ? $clog2(MAX_DBURST + 1) : 3;

    state_t        state, next_state;
    logic          dreq;
    logic          ifirst;
    logic [CW-1:0] dstreak;

    assign dreq  = dREN | dWEN;
    assign iload = ramload;
    assign dload = ramload;

`ifdef ARB_FAIRNESS_EN
    // Counts dcache words served while the icache is held off; saturates at MAX_DBURST.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            dstreak <= '0;
        end else if (!iREN || !iwait) begin
            dstreak <= '0;
        end else if (!dwait && (dstreak < CW'(MAX_DBURST))) begin
            dstreak <= dstreak + CW'(1);
        end
    end
`else
    assign dstreak = '0;
`endif

    assign ifirst = iREN && (dstreak >= CW'(MAX_DBURST));

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        unique case (state)
            IDLE: begin
                if (ifirst)      next_state = IGRANT;
                else if (dreq)   next_state = DGRANT;
                else if (iREN)   next_state = IGRANT;
            end
            DGRANT: begin
                // A withdrawn request abandons the access and ignores ramready.
                if (!dreq) begin
                    next_state = IDLE;
                end else begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramready) begin
                        dwait      = 1'b0;
                        next_state = IDLE;
                    end
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramready) begin
                        iwait      = 1'b0;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized
// two-cache traffic against a RAM model, with a per-cache scoreboard.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    localparam int unsigned MAX_DBURST = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [31:0] ramload = '0;
    logic        ramready = 1'b0;

    cache_mem_arbiter #(.MAX_DBURST(MAX_DBURST)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // RAM model: random latency in auto mode, else mirrors man_ready/man_load.
    bit          ram_auto = 1'b0;
    logic        man_ready = 1'b0;
    logic [31:0] man_load = '0;
    logic [31:0] ram_mem [logic [31:0]];
    int          lat, cnt;
    bit          busy = 1'b0;

    always @(posedge CLK) begin
        #2;
        if (!ram_auto) begin
            ramready = man_ready;
            ramload  = man_load;
            busy     = 1'b0;
        end else if (ramREN || ramWEN) begin
            if (!busy) begin
                busy = 1'b1;
                lat  = $urandom_range(0, 3);
                cnt  = 0;
            end
            if (cnt == lat) begin
                ramready = 1'b1;
                busy     = 1'b0;
                if (ramWEN) ram_mem[ramaddr] = ramstore;
                else ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_word(ramaddr);
            end else begin
                ramready = 1'b0;
                cnt++;
            end
        end else begin
            ramready = 1'b0;
            busy     = 1'b0;
        end
    end

    // Scoreboard: expected completions per cache, in issue order.
    typedef struct {bit rd; logic [31:0] data;} exp_t;
    exp_t        dq[$];
    exp_t        iq[$];
    exp_t        e;
    logic [31:0] ref_mem [logic [31:0]];
    bit          sb_en = 1'b0;

    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            chk("both_waits_low", {31'b0, ~iwait & ~dwait}, 32'd0);
            chk("both_strobes", {31'b0, ramREN & ramWEN}, 32'd0);
            if (ramWEN)
                chk("write_owner", {31'b0, dWEN && ramaddr == daddr && ramstore == dstore}, 32'd1);
            if (ramREN)
                chk("read_owner", {31'b0, (dREN && !dWEN && ramaddr == daddr) ||
                                          (iREN && ramaddr == iaddr)}, 32'd1);
            if (sb_en && !dwait) begin
                if (dq.size() == 0) chk("dcache_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = dq.pop_front();
                    if (e.rd) chk("dcache_load", dload, e.data);
                end
            end
            if (sb_en && !iwait) begin
                if (iq.size() == 0) chk("icache_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = iq.pop_front();
                    chk("icache_load", iload, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic dcache_agent(input int n);
        for (int k = 0; k < n; k++) begin
            int          gap;
            int          t;
            logic [31:0] a;
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            a = 32'h1000 + ($urandom_range(0, 15) << 2);
            daddr = a;
            if ($urandom_range(0, 2) == 0) begin
                dWEN   = 1'b1;
                dREN   = 1'($urandom_range(0, 1));
                dstore = $urandom;
                ref_mem[a] = dstore;
                dq.push_back('{rd: 1'b0, data: 32'h0});
            end else begin
                dREN = 1'b1;
                dq.push_back('{rd: 1'b1, data: ref_mem.exists(a) ? ref_mem[a] : init_word(a)});
            end
            t = 0;
            forever begin
                @(negedge CLK);
                if (!dwait) break;
                t++;
                if (t > 200) begin
                    chk("dcache_timeout", 32'd1, 32'd0);
                    break;
                end
            end
            tick();
            dREN = 1'b0;
            dWEN = 1'b0;
        end
    endtask

    task automatic icache_agent(input int n);
        for (int k = 0; k < n; k++) begin
            int          gap;
            int          t;
            logic [31:0] a;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            a = $urandom_range(0, 15) << 2;
            iaddr = a;
            iREN  = 1'b1;
            iq.push_back('{rd: 1'b1, data: init_word(a)});
            t = 0;
            forever begin
                @(negedge CLK);
                if (!iwait) break;
                t++;
                if (t > 200) begin
                    chk("icache_timeout", 32'd1, 32'd0);
                    break;
                end
            end
            tick();
            iREN = 1'b0;
        end
    endtask

    initial begin
        bit ev[$];
        bit fair;
        int streak;
        bit want;

        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        repeat (2) tick();
        nRST = 1'b1;
        @(negedge CLK);
        chk("reset_iwait", {31'b0, iwait}, 32'd1);
        chk("reset_dwait", {31'b0, dwait}, 32'd1);
        chk("reset_ramREN", {31'b0, ramREN}, 32'd0);
        chk("reset_ramaddr", ramaddr, 32'd0);

        // Asynchronous reset in the middle of a dcache grant.
        tick();
        dREN = 1'b1; daddr = 32'h200;
        tick();
        @(negedge CLK);
        chk("pre_rst_dgrant", {31'b0, ramREN}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("rst_mid_iwait", {31'b0, iwait}, 32'd1);
        chk("rst_mid_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_mid_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
        chk("rst_mid_ramaddr", ramaddr, 32'd0);
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        chk("rst_release_idle", {31'b0, ramREN}, 32'd0);
        tick();
        dREN = 1'b0;
        tick();

        // dcache read, RAM ready three cycles after the strobe.
        dREN = 1'b1; daddr = 32'h40;
        @(negedge CLK);
        chk("dread_idle_cycle", {31'b0, ramREN}, 32'd0);
        tick();
        @(negedge CLK);
        chk("dread_strobe", {31'b0, ramREN}, 32'd1);
        chk("dread_addr", ramaddr, 32'h40);
        chk("dread_wait_hold", {31'b0, dwait}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge CLK);
            chk("dread_wait_hold", {31'b0, dwait}, 32'd1);
        end
        tick();
        man_ready = 1'b1; man_load = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("dread_done", {31'b0, dwait}, 32'd0);
        chk("dread_data", dload, 32'hDEAD_BEEF);
        tick();
        dREN = 1'b0; man_ready = 1'b0;
        @(negedge CLK);
        chk("dread_bubble_wait", {31'b0, dwait}, 32'd1);
        chk("dread_bubble_strobe", {31'b0, ramREN}, 32'd0);

        // Write wins over read and over a simultaneous icache request.
        tick();
        iREN = 1'b1; iaddr = 32'h8;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234_5678;
        tick();
        @(negedge CLK);
        chk("wp_ramWEN", {31'b0, ramWEN}, 32'd1);
        chk("wp_ramREN", {31'b0, ramREN}, 32'd0);
        chk("wp_ramstore", ramstore, 32'h1234_5678);
        chk("wp_ramaddr", ramaddr, 32'h80);
        chk("wp_iwait", {31'b0, iwait}, 32'd1);
        tick();
        man_ready = 1'b1;
        @(negedge CLK);
        chk("wp_ddone", {31'b0, dwait}, 32'd0);
        chk("wp_iwait_during", {31'b0, iwait}, 32'd1);
        tick();
        dREN = 1'b0; dWEN = 1'b0; man_ready = 1'b0;
        @(negedge CLK);
        chk("wp_bubble_iwait", {31'b0, iwait}, 32'd1);
        tick();
        @(negedge CLK);
        chk("wp_igrant_strobe", {31'b0, ramREN}, 32'd1);
        chk("wp_igrant_addr", ramaddr, 32'h8);
        tick();
        man_ready = 1'b1; man_load = 32'hCAFE_0008;
        @(negedge CLK);
        chk("wp_idone", {31'b0, iwait}, 32'd0);
        chk("wp_iload", iload, 32'hCAFE_0008);
        tick();
        iREN = 1'b0; man_ready = 1'b0;
        tick();

        // icache withdraws while granted; the late ramready must be ignored.
        iREN = 1'b1; iaddr = 32'h10;
        tick();
        @(negedge CLK);
        chk("wd_igrant", {31'b0, ramREN}, 32'd1);
        tick();
        iREN = 1'b0; man_ready = 1'b1;
        @(negedge CLK);
        chk("wd_iwait", {31'b0, iwait}, 32'd1);
        chk("wd_dwait", {31'b0, dwait}, 32'd1);
        chk("wd_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
        tick();
        man_ready = 1'b0;
        @(negedge CLK);
        chk("wd_idle", {31'b0, ramREN | iwait ^ 1'b1}, 32'd0);
        tick();

        // Back-to-back dcache traffic with the icache continuously requesting.
        iREN = 1'b1; iaddr = 32'h20; dREN = 1'b1; daddr = 32'h100; man_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLK);
            if (!dwait) ev.push_back(1'b0);
            if (!iwait) ev.push_back(1'b1);
            tick();
        end
`ifdef ARB_FAIRNESS_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        chk("fair_event_count", ev.size(), 32'd12);
        streak = 0;
        for (int k = 0; k < ev.size(); k++) begin
            want = fair && (streak >= int'(MAX_DBURST));
            streak = want ? 0 : streak + 1;
            chk("fair_sequence", {31'b0, ev[k]}, {31'b0, want});
        end
        iREN = 1'b0; dREN = 1'b0; man_ready = 1'b0;
        repeat (2) tick();

        // Randomized concurrent traffic against the scoreboard.
        ram_auto = 1'b1;
        sb_en    = 1'b1;
        fork
            dcache_agent(300);
            icache_agent(200);
        join
        repeat (5) tick();
        chk("dq_drained", dq.size(), 32'd0);
        chk("iq_drained", iq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
